// File: rtl/nlms_weight_update.sv
// Serial NLMS coefficient updater: one tap per clock, saturating w[k] += (e*x[k+1]) >>> MU_SHIFT.
// Weights sit in per-tap register lanes and are published flat to the filter datapath.

module nlms_wreg (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)      q <= '0;
    else if (wr_en) q <= wr_data;
endmodule

module nlms_weight_update #(
  parameter int MU_SHIFT = 12,
  parameter int NTAP     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 upd_en,
  input  logic                 start,
  input  logic [13:0]          e,
  output logic [5:0]           tap_idx,
  input  logic [13:0]          tap_sample,
  input  logic                 w_ld,
  input  logic [4:0]           w_ld_idx,
  input  logic [31:0]          w_ld_data,
  output logic [NTAP*32-1:0]   weight_flat,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t                    state, state_nxt;
  logic [4:0]                k;
  logic signed [13:0]        e_q;
  logic [NTAP-1:0][31:0]     w;
  logic                      accept, upd_wr, ld_fire;
  logic signed [28:0]        prod;
  logic signed [32:0]        prod_x, delta;
  logic [33:0]               sum;
  logic [31:0]               w_cur, w_sat;

  assign accept  = (state == IDLE) && start && upd_en;
  assign ld_fire = (state == IDLE) && w_ld && !accept;
  // An abort cycle (upd_en low) must not write the tap it is sitting on.
  assign upd_wr  = (state == UPDATE) && upd_en;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      k     <= '0;
      e_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        e_q <= $signed(e);
        k   <= '0;
      end else if (state == UPDATE) begin
        k <= k + 5'd1;
      end
    end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = UPDATE;
      UPDATE:  if (!upd_en) state_nxt = IDLE;
               else if (k == 5'(NTAP-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared step datapath; sample is unsigned so it gets a zero sign bit.
  assign prod   = e_q * $signed({1'b0, tap_sample});
  assign prod_x = {{4{prod[28]}}, prod};
  assign delta  = prod_x >>> MU_SHIFT;
  assign w_cur  = w[k];
  assign sum    = {2'b00, w_cur} + {delta[32], delta};
  assign w_sat  = sum[33] ? 32'h0 : (sum[32] ? 32'hFFFF_FFFF : sum[31:0]);

  genvar i;
  generate
    for (i = 0; i < NTAP; i++) begin : g_lane
      logic wr_en;
      assign wr_en = (upd_wr && k == 5'(i)) || (ld_fire && w_ld_idx == 5'(i));
      nlms_wreg u_wreg (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_data (upd_wr ? w_sat : w_ld_data),
        .q       (w[i])
      );
    end
  endgenerate

  assign weight_flat = w;
  assign busy        = (state == UPDATE);
  assign done        = (state == DONE);
  assign tap_idx     = (state == UPDATE) ? ({1'b0, k} + 6'd1) : 6'd0;
endmodule

// File: tb/tb_nlms_weight_update.sv
// Directed bench for nlms_weight_update with a combinational sample-buffer model.

module tb_nlms_weight_update;
  logic          clk = 0;
  logic          rstn;
  logic          upd_en, start, w_ld;
  logic [13:0]   e, tap_sample;
  logic [5:0]    tap_idx;
  logic [4:0]    w_ld_idx;
  logic [31:0]   w_ld_data;
  logic [1023:0] weight_flat;
  logic          busy, done;
  logic [13:0]   smp [0:63];
  int            total = 0, bad = 0;

  always #5 clk = ~clk;
  assign tap_sample = smp[tap_idx];

  nlms_weight_update #(.MU_SHIFT(12), .NTAP(32)) dut (
    .clk(clk), .rstn(rstn), .upd_en(upd_en), .start(start), .e(e),
    .tap_idx(tap_idx), .tap_sample(tap_sample), .w_ld(w_ld), .w_ld_idx(w_ld_idx),
    .w_ld_data(w_ld_data), .weight_flat(weight_flat), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wt(input int k);
    return weight_flat[32*k +: 32];
  endfunction

  task automatic set_smp(input logic [13:0] v);
    for (int i = 0; i < 64; i++) smp[i] = v;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    w_ld = 1; w_ld_idx = 5'(idx); w_ld_data = d;
    @(posedge clk); #1;
    w_ld = 0;
  endtask

  // Called 1ns into a cycle; returns 1ns into the first IDLE cycle after done.
  task automatic do_update(input logic [13:0] ev);
    int n;
    start = 1; e = ev; upd_en = 1;
    @(posedge clk); #1;
    start = 0; w_ld = 0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("upd_done", done, 1);
    chk("upd_lat", n, 32);
    chk("done_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt, dn;
    rstn = 0; upd_en = 0; start = 0; e = 0; w_ld = 0; w_ld_idx = 0; w_ld_data = 0;
    set_smp(14'd64);
    #12;
    chk("rst_w", 64'(weight_flat == '0), 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tap", tap_idx, 0);
    rstn = 1;
    @(posedge clk); #1;

    // Basic step: 6400 >>> 12 = 1 on every tap, tap_idx walks 1..32.
    start = 1; e = 14'd100; upd_en = 1;
    @(posedge clk); #1;
    start = 0;
    cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      if (tap_idx == 6'(c) && busy) cnt++;
      if (c == 2) chk("basic_w0_t2", wt(0), 1);
      @(posedge clk); #1;
    end
    chk("basic_tapseq", cnt, 32);
    chk("basic_done", done, 1);
    chk("basic_busy_off", busy, 0);
    @(posedge clk); #1;
    chk("basic_done_1cyc", done, 0);
    cnt = 0;
    for (int k = 0; k < 32; k++) if (wt(k) == 32'd1) cnt++;
    chk("basic_all1", cnt, 32);

    // Negative floor and lower clamp.
    preload(0, 32'd5);
    preload(1, 32'd0);
    chk("pre_w0", wt(0), 5);
    set_smp(14'd1);
    do_update(14'h3FFF);
    chk("neg_w0", wt(0), 4);
    chk("neg_w1", wt(1), 0);
    chk("neg_w31", wt(31), 0);

    // Upper saturation plus a large non-saturating step.
    preload(31, 32'hFFFF_FFF0);
    set_smp(14'd0);
    smp[1] = 14'd16383; smp[32] = 14'd16383;
    do_update(14'd8191);
    chk("sat_w31", wt(31), 32'hFFFF_FFFF);
    chk("big_w0", wt(0), 32'd32766);
    chk("big_w1", wt(1), 0);

    // Re-pulsed start during UPDATE and DONE is ignored.
    set_smp(14'd0);
    start = 1; e = 14'd100;
    @(posedge clk); #1;
    start = 0; dn = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 33);
      if (done) begin dn++; chk("ctl_done_cyc", c, 33); end
      if (c == 34) chk("ctl_idle_busy", busy, 0);
      @(posedge clk); #1;
    end
    start = 0;
    chk("ctl_one_done", dn, 1);

    // start without upd_en stays IDLE.
    upd_en = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("noen_busy", busy, 0);
    chk("noen_tap", tap_idx, 0);
    @(posedge clk); #1;
    chk("noen_done", done, 0);

    // Abort at T+10.
    for (int k = 0; k < 32; k++) preload(k, 32'd1000);
    set_smp(14'd64);
    upd_en = 1; start = 1; e = 14'd100;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    upd_en = 0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_tap", tap_idx, 0);
    dn = 0;
    for (int c = 0; c < 30; c++) begin if (done) dn++; @(posedge clk); #1; end
    chk("abort_nodone", dn, 0);
    cnt = 0;
    for (int k = 0; k < 9; k++) if (wt(k) == 32'd1001) cnt++;
    chk("abort_upd", cnt, 9);
    cnt = 0;
    for (int k = 9; k < 32; k++) if (wt(k) == 32'd1000) cnt++;
    chk("abort_keep", cnt, 23);

    // Preload/start collision: start wins.
    w_ld = 1; w_ld_idx = 5'd5; w_ld_data = 32'd12345;
    do_update(14'd100);
    chk("coll_w5", wt(5), 32'd1002);
    chk("coll_w9", wt(9), 32'd1001);

    // Asynchronous reset mid-update.
    start = 1; e = 14'd100; upd_en = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 5; c++) begin @(posedge clk); #1; end
    chk("mid_busy_pre", busy, 1);
    #2 rstn = 0;
    #1;
    chk("mid_rst_w", 64'(weight_flat == '0), 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tap", tap_idx, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rstn = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
